// File: rtl/ac_stage_sequencer_pkg.sv
// Shared control definitions for the stage-A/stage-C sequencer and its helpers.
// Holds the sequencer state encoding and the legal parameter ranges used by assertions.
package ac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ac_state_e;

  localparam int LAT_MIN          = 1;
  localparam int LAT_MAX          = 4;
  localparam int MAX_INFLIGHT_MIN = 1;

  function automatic bit lat_legal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  function automatic bit inflight_legal(input int max_inflight);
    return max_inflight >= MAX_INFLIGHT_MIN;
  endfunction

endpackage

// File: rtl/ac_stage_sequencer_if.sv
// Command/status bundle between the sequencer and whoever commands it.
// The master side issues start/count and reports stage-C back-pressure.
interface ac_stage_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             stall_c;
  logic             en_a;
  logic             en_c;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, count, stall_c,
    input  en_a, en_c, busy, done, issued, retired
  );

  modport slave (
    input  start, count, stall_c,
    output en_a, en_c, busy, done, issued, retired
  );
endinterface

// File: rtl/ac_stage_sequencer_token_delay.sv
// DEPTH-deep single-bit token shift register; a token injected at cycle t
// is presented on o_tok during cycle t+DEPTH.
module token_delay
  import ac_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tok,
  output logic o_tok
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_tok;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_tok = r_sr[DEPTH-1];

  a_depth_legal: assert property (@(posedge clk) lat_legal(DEPTH));

endmodule

// File: rtl/ac_stage_sequencer.sv
// Issue/retire sequencer: generates the stage-A and stage-C flop enables for a
// commanded number of operations, with LAT-cycle spacing and stage-C back-pressure.
//
// state    | meaning
// ST_IDLE  | waiting for start; counters hold results of the last run
// ST_RUN   | issuing en_a until the latched count has been issued
// ST_DRAIN | all issued; retiring the remaining tokens through en_c
// ST_DONE  | one-cycle completion pulse, then back to ST_IDLE
module ac_stage_sequencer
  import ac_ctrl_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int LAT          = 1,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                 clk,
  input logic                 rst,
  ac_stage_sequencer_if.slave bus
);

  localparam int PEND_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_IF = CNT_W'(MAX_INFLIGHT);

  ac_state_e          r_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_retired;
  logic [PEND_W-1:0]  r_pending;

  logic               w_en_a;
  logic               w_en_c;
  logic               w_tok_arrive;
  logic [CNT_W-1:0]   w_inflight;
  logic [PEND_W-1:0]  w_pending_eff;

  assign w_inflight = r_issued - r_retired;

  assign w_en_a = (r_state == ST_RUN) && (r_issued < r_count) && (w_inflight < MAX_IF);

  token_delay #(
    .DEPTH (LAT)
  ) u_token_delay (
    .clk   (clk),
    .rst   (rst),
    .i_tok (w_en_a),
    .o_tok (w_tok_arrive)
  );

  // A token arriving this cycle is already eligible, so it counts toward pending now.
  assign w_pending_eff = r_pending + PEND_W'(w_tok_arrive);
  assign w_en_c        = (w_pending_eff != '0) && !bus.stall_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_eff - PEND_W'(w_en_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_issued  <= '0;
      r_retired <= '0;
    end else begin
      if (w_en_a) r_issued  <= r_issued + 1'b1;
      if (w_en_c) r_retired <= r_retired + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_count   <= bus.count;
            r_issued  <= '0;
            r_retired <= '0;
            r_state   <= (bus.count == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_en_a && ((r_issued + 1'b1) == r_count)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Leave on the final retire so done lands one cycle after the last en_c.
          if (w_en_c && ((r_retired + 1'b1) == r_count)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.en_a    = w_en_a;
  assign bus.en_c    = w_en_c;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.issued  = r_issued;
  assign bus.retired = r_retired;

  a_param_legal: assert property (@(posedge clk)
    lat_legal(LAT) && inflight_legal(MAX_INFLIGHT));

  a_en_c_needs_pending: assert property (@(posedge clk) disable iff (rst)
    w_en_c |-> (w_pending_eff != '0));

  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    w_inflight <= MAX_IF);

  a_pending_bound: assert property (@(posedge clk) disable iff (rst)
    int'(r_pending) <= MAX_INFLIGHT);

  a_done_only_in_done: assert property (@(posedge clk) disable iff (rst)
    bus.done |-> (r_state == ST_DONE));

endmodule

// File: tb/tb_ac_stage_sequencer.sv
// Self-checking bench for ac_stage_sequencer: a LAT=1 and a LAT=4 instance checked
// against a queue-based model of issue times, plus directed tables and corner sequences.
module tb_ac_stage_sequencer;

  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ac_stage_sequencer_if #(.CNT_W(8)) bus1 ();
  ac_stage_sequencer_if #(.CNT_W(8)) bus4 ();

  ac_stage_sequencer #(.CNT_W(8), .LAT(1), .MAX_INFLIGHT(MAXI)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  ac_stage_sequencer #(.CNT_W(8), .LAT(4), .MAX_INFLIGHT(MAXI)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_pass  = 0;
  int n_total = 0;

  // selected DUT and its sampled outputs
  int sel = 0;
  int o_en_a, o_en_c, o_busy, o_done, o_issued, o_retired;

  // reference model: issue times of tokens not yet retired
  bit m_busy, m_done;
  int m_n, m_iss, m_ret, m_lat, cyc;
  int m_q[$];

  typedef struct {
    bit st;
    int cnt;
    bit stl;
    int en_a, en_c, busy, done, issued, retired;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s c%0d: got %0d expected %0d", nm, cyc, act, exp_v);
  endtask

  task automatic fetch();
    if (sel == 0) begin
      o_en_a = int'(bus1.en_a); o_en_c = int'(bus1.en_c);
      o_busy = int'(bus1.busy); o_done = int'(bus1.done);
      o_issued = int'(bus1.issued); o_retired = int'(bus1.retired);
    end else begin
      o_en_a = int'(bus4.en_a); o_en_c = int'(bus4.en_c);
      o_busy = int'(bus4.busy); o_done = int'(bus4.done);
      o_issued = int'(bus4.issued); o_retired = int'(bus4.retired);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_n = 0; m_iss = 0; m_ret = 0; cyc = 0;
    m_lat = (sel == 0) ? 1 : 4;
    m_q.delete();
  endtask

  task automatic drive(input bit st, input int cnt, input bit stl);
    bus1.start = 0; bus1.count = 8'd0; bus1.stall_c = 0;
    bus4.start = 0; bus4.count = 8'd0; bus4.stall_c = 0;
    if (sel == 0) begin
      bus1.start = st; bus1.count = 8'(cnt); bus1.stall_c = stl;
    end else begin
      bus4.start = st; bus4.count = 8'(cnt); bus4.stall_c = stl;
    end
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    sel = s;
    drive(0, 0, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit st, input int cnt, input bit stl);
    bit e_a, e_c;
    @(negedge clk);
    drive(st, cnt, stl);
    #1;
    fetch();
    e_a = m_busy && !m_done && (m_iss < m_n) && ((m_iss - m_ret) < MAXI);
    e_c = 0;
    if (m_q.size() > 0 && !stl) e_c = (m_q[0] + m_lat <= cyc);
    chk("en_a", o_en_a, int'(e_a));
    chk("en_c", o_en_c, int'(e_c));
    chk("busy", o_busy, int'(m_busy));
    chk("done", o_done, int'(m_done));
    chk("issued", o_issued, m_iss);
    chk("retired", o_retired, m_ret);
    if (e_a) begin m_iss++; m_q.push_back(cyc); end
    if (e_c) begin m_ret++; void'(m_q.pop_front()); end
    if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      if (m_ret == m_n) m_done = 1;
    end else if (st) begin
      m_n = cnt; m_iss = 0; m_ret = 0; m_q.delete();
      m_busy = 1; m_done = (cnt == 0);
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nc, nd, nc_win;
    int a_t[$];
    int c_t[$];

    // basic run (5), zero count, start during RUN and during DONE
    tbl[0]  = '{1, 5, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 1, 0, 2, 1};
    tbl[4]  = '{0, 0, 0, 1, 1, 1, 0, 3, 2};
    tbl[5]  = '{0, 0, 0, 1, 1, 1, 0, 4, 3};
    tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 5, 4};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, 5, 5};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 5, 5};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 5, 5};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 2, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 3, 0, 1, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 1, 1, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 1, 1, 0, 2, 1};
    tbl[16] = '{1, 3, 0, 0, 0, 1, 1, 2, 2};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 2, 2};

    drive(0, 0, 0);
    #12;

    // reset values on both instances
    for (int s = 0; s < 2; s++) begin
      do_reset(s);
      #1;
      fetch();
      chk("rst_en_a", o_en_a, 0);
      chk("rst_en_c", o_en_c, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_issued", o_issued, 0);
      chk("rst_retired", o_retired, 0);
    end

    // table-driven directed vectors
    do_reset(0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].st, tbl[i].cnt, tbl[i].stl);
      chk("tbl_en_a", o_en_a, tbl[i].en_a);
      chk("tbl_en_c", o_en_c, tbl[i].en_c);
      chk("tbl_busy", o_busy, tbl[i].busy);
      chk("tbl_done", o_done, tbl[i].done);
      chk("tbl_issued", o_issued, tbl[i].issued);
      chk("tbl_retired", o_retired, tbl[i].retired);
    end

    // stall to the in-flight limit: count 10, stall_c over cycles 1..8
    do_reset(0);
    na = 0; nd = 0; nc_win = 0;
    step(1, 10, 0);
    for (int k = 1; k < 60; k++) begin
      step(0, 0, (k >= 1 && k <= 8));
      if (k <= 8 && o_en_a != 0) na++;
      if (k >= 9 && k <= 18 && o_en_c != 0) nc_win++;
      if (o_done != 0) nd++;
      if (!m_busy) break;
    end
    chk("stall_en_a_pulses", na, 4);
    chk("stall_retire_window", nc_win, 10);
    chk("stall_done_once", nd, 1);
    chk("stall_retired_final", o_retired, 10);

    // mid-run asynchronous reset with two operations in flight
    do_reset(0);
    step(1, 5, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    @(negedge clk);
    #2;
    fetch();
    chk("prerst_busy", o_busy, 1);
    chk("prerst_issued", o_issued, 2);
    rst = 1'b1;
    #1;
    fetch();
    chk("async_en_a", o_en_a, 0);
    chk("async_en_c", o_en_c, 0);
    chk("async_busy", o_busy, 0);
    chk("async_done", o_done, 0);
    chk("async_issued", o_issued, 0);
    chk("async_retired", o_retired, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    na = 0; nc = 0;
    step(1, 2, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      na += o_en_a;
      nc += o_en_c;
      if (!m_busy) break;
    end
    chk("postrst_en_a_pulses", na, 2);
    chk("postrst_en_c_pulses", nc, 2);

    // deep latency with stall_c toggling every cycle
    do_reset(1);
    step(1, 3, 0);
    for (int k = 1; k < 60; k++) begin
      step(0, 0, bit'(k % 2));
      if (o_en_a != 0) a_t.push_back(k);
      if (o_en_c != 0) begin
        c_t.push_back(k);
        chk("deep_en_c_under_stall", k % 2, 0);
      end
      if (!m_busy) break;
    end
    chk("deep_en_a_count", a_t.size(), 3);
    chk("deep_en_c_count", c_t.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < a_t.size() && i < c_t.size())
        chk("deep_spacing_ok", int'(c_t[i] - a_t[i] >= 4), 1);
    end

    // randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      do_reset(s);
      for (int k = 0; k < 400; k++) begin
        step(($urandom % 6) == 0, int'($urandom % 13), ($urandom % 3) == 0);
      end
      for (int k = 0; k < 80 && m_busy; k++) step(0, 0, 0);
      step(0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
